// File: rtl/wback_arb_pkg.sv
// Shared constants and helpers for the writeback arbiter.
// Configuration macro: WBACK_ARB_RR_EN (round-robin conflict resolution when defined).
package wback_arb_pkg;

    localparam logic       WB_SRC_ALU   = 1'b0;
    localparam logic       WB_SRC_MEM   = 1'b1;
    localparam logic [1:0] SEL_ALU_DATA = 2'b00;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Writes to x0 are architecturally discarded, so the enable is dropped at load time.
    function automatic logic wena_filter(input logic wena, input logic [4:0] waddr);
        return wena && (waddr != 5'd0);
    endfunction

endpackage

// File: rtl/wback_arb_grant.sv
// Two-way grant logic for the writeback arbiter: round-robin or fixed MEM priority.
// Configuration macro: WBACK_ARB_RR_EN.
module wback_arb_grant
    import wback_arb_pkg::*;
(
`ifdef WBACK_ARB_RR_EN
    input  logic clock,
    input  logic reset,
`endif
    input  logic alu_req_i,
    input  logic mem_req_i,
    input  logic can_load_i,
    output logic alu_gnt_o,
    output logic mem_gnt_o
);

`ifdef WBACK_ARB_RR_EN
    // last_q holds the source granted most recently; reset value ALU lets MEM win first.
    logic last_q;
    logic last_d;
`endif

    // Conflict resolution between the two requesters.
    always_comb begin
        alu_gnt_o = 1'b0;
        mem_gnt_o = 1'b0;
        if (can_load_i) begin
            if (alu_req_i && mem_req_i) begin
`ifdef WBACK_ARB_RR_EN
                mem_gnt_o = (last_q == WB_SRC_ALU);
                alu_gnt_o = (last_q == WB_SRC_MEM);
`else
                mem_gnt_o = 1'b1;
`endif
            end else begin
                alu_gnt_o = alu_req_i;
                mem_gnt_o = mem_req_i;
            end
        end else begin
            alu_gnt_o = 1'b0;
            mem_gnt_o = 1'b0;
        end
    end

`ifdef WBACK_ARB_RR_EN
    // Pointer follows every grant, conflicting or not.
    always_comb begin
        if (mem_gnt_o) begin
            last_d = WB_SRC_MEM;
        end else if (alu_gnt_o) begin
            last_d = WB_SRC_ALU;
        end else begin
            last_d = last_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: rtl/wback_arb.sv
// Writeback arbiter: merges ALU and load-unit results into one registered output slot.
// Configuration macro: WBACK_ARB_RR_EN (see wback_arb_grant).
module wback_arb
    import wback_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic              alu_wena_i,
    input  logic [4:0]        alu_waddr_i,
    input  logic [DATA_W-1:0] alu_wdata_i,
    input  logic              alu_csr_wena_i,
    input  logic [31:0]       alu_csr_waddr_i,
    input  logic [DATA_W-1:0] alu_csr_wdata_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic              mem_wena_i,
    input  logic [4:0]        mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic              wena_o,
    output logic [4:0]        waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              csr_wena_o,
    output logic [31:0]       csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              wb_src_o
);

    logic [0:0]        state_q, state_d;
    logic              wena_q, wena_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              csr_wena_q, csr_wena_d;
    logic [31:0]       csr_waddr_q, csr_waddr_d;
    logic [DATA_W-1:0] csr_wdata_q, csr_wdata_d;
    logic              src_q, src_d;

    logic can_load_s;
    logic alu_gnt_s;
    logic mem_gnt_s;

    assign can_load_s = (state_q == ST_EMPTY) || wb_ready_i;

    wback_arb_grant u_grant (
`ifdef WBACK_ARB_RR_EN
        .clock      (clock),
        .reset      (reset),
`endif
        .alu_req_i  (alu_valid_i),
        .mem_req_i  (mem_valid_i),
        .can_load_i (can_load_s),
        .alu_gnt_o  (alu_gnt_s),
        .mem_gnt_o  (mem_gnt_s)
    );

    // Readies are forced low while reset is held so no requester sees a phantom accept.
    assign alu_ready_o = alu_gnt_s && reset;
    assign mem_ready_o = mem_gnt_s && reset;

    // Slot FSM and payload capture; contents only change on a grant.
    always_comb begin
        state_d     = state_q;
        wena_d      = wena_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        csr_wena_d  = csr_wena_q;
        csr_waddr_d = csr_waddr_q;
        csr_wdata_d = csr_wdata_q;
        src_d       = src_q;
        case ({alu_gnt_s, mem_gnt_s})
            2'b10: begin
                state_d     = ST_FULL;
                wena_d      = wena_filter(alu_wena_i, alu_waddr_i);
                waddr_d     = alu_waddr_i;
                wdata_d     = alu_wdata_i;
                csr_wena_d  = alu_csr_wena_i;
                csr_waddr_d = alu_csr_waddr_i;
                csr_wdata_d = alu_csr_wdata_i;
                src_d       = WB_SRC_ALU;
            end
            2'b01: begin
                state_d     = ST_FULL;
                wena_d      = wena_filter(mem_wena_i, mem_waddr_i);
                waddr_d     = mem_waddr_i;
                wdata_d     = mem_wdata_i;
                csr_wena_d  = 1'b0;
                csr_waddr_d = 32'd0;
                csr_wdata_d = '0;
                src_d       = WB_SRC_MEM;
            end
            default: begin
                if (wb_ready_i) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = state_q;
                end
            end
        endcase
    end

    // Output slot registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            wena_q      <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= '0;
            csr_wena_q  <= 1'b0;
            csr_waddr_q <= 32'd0;
            csr_wdata_q <= '0;
            src_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wena_q      <= wena_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            csr_wena_q  <= csr_wena_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            src_q       <= src_d;
        end
    end

    assign wb_valid_o  = (state_q == ST_FULL);
    assign wena_o      = wena_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign csr_wena_o  = csr_wena_q;
    assign csr_waddr_o = csr_waddr_q;
    assign csr_wdata_o = csr_wdata_q;
    assign wb_src_o    = src_q;

endmodule

// File: tb/tb_wback_arb.sv
// Directed scoreboard bench for wback_arb; expected entries are queued at grant and checked at load.
module tb_wback_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid_i, alu_ready_o, alu_wena_i, alu_csr_wena_i;
    logic [4:0]  alu_waddr_i;
    logic [31:0] alu_wdata_i, alu_csr_waddr_i, alu_csr_wdata_i;
    logic        mem_valid_i, mem_ready_o, mem_wena_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        wb_valid_o, wb_ready_i;
    logic        wena_o, csr_wena_o, wb_src_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o, csr_waddr_o, csr_wdata_o;

    typedef struct packed {
        logic        wena;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        csr_wena;
        logic [31:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        src;
    } entry_t;

    entry_t obs_s;
    entry_t sb_q[$];
    entry_t cur;
    bit     m_valid;
`ifdef WBACK_ARB_RR_EN
    bit     m_ptr;
`endif
    int     vectors = 0;
    int     miscompares = 0;

    always #5 clock = ~clock;

    assign obs_s = {wena_o, waddr_o, wdata_o, csr_wena_o, csr_waddr_o, csr_wdata_o, wb_src_o};

    wback_arb #(.DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_wena_i(alu_wena_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .alu_csr_wena_i(alu_csr_wena_i), .alu_csr_waddr_i(alu_csr_waddr_i),
        .alu_csr_wdata_i(alu_csr_wdata_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_wena_i(mem_wena_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wena_o(wena_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .csr_wena_o(csr_wena_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .wb_src_o(wb_src_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs set; models one cycle and checks readies and slot.
    task automatic tick(input string tag);
        bit ga, gm, can;
        entry_t e;
        @(negedge clock);
        can = !m_valid || wb_ready_i;
        ga = 1'b0;
        gm = 1'b0;
        if (can) begin
            if (alu_valid_i && mem_valid_i) begin
`ifdef WBACK_ARB_RR_EN
                gm = !m_ptr;
`else
                gm = 1'b1;
`endif
                ga = !gm;
            end else begin
                ga = alu_valid_i;
                gm = mem_valid_i;
            end
        end
        check({tag, "/ready"}, {126'd0, alu_ready_o, mem_ready_o}, {126'd0, ga, gm});
        if (ga) begin
            e = '{alu_wena_i && (alu_waddr_i != 5'd0), alu_waddr_i, alu_wdata_i,
                  alu_csr_wena_i, alu_csr_waddr_i, alu_csr_wdata_i, 1'b0};
            sb_q.push_back(e);
        end else if (gm) begin
            e = '{mem_wena_i && (mem_waddr_i != 5'd0), mem_waddr_i, mem_wdata_i,
                  1'b0, 32'd0, 32'd0, 1'b1};
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        if (ga || gm) begin
            m_valid = 1'b1;
            cur = sb_q.pop_front();
`ifdef WBACK_ARB_RR_EN
            m_ptr = gm;
`endif
            if (ga) alu_valid_i = 1'b0;
            if (gm) mem_valid_i = 1'b0;
        end else if (wb_ready_i) begin
            m_valid = 1'b0;
        end
        check({tag, "/valid"}, {127'd0, wb_valid_o}, {127'd0, m_valid});
        if (m_valid) check({tag, "/slot"}, {24'd0, obs_s}, {24'd0, cur});
    endtask

    initial begin
        reset = 1'b0;
        {alu_valid_i, alu_wena_i, alu_csr_wena_i, mem_valid_i, mem_wena_i, wb_ready_i} = 6'd0;
        alu_waddr_i = 5'd0; alu_wdata_i = 32'd0; alu_csr_waddr_i = 32'd0; alu_csr_wdata_i = 32'd0;
        mem_waddr_i = 5'd0; mem_wdata_i = 32'd0;
        m_valid = 1'b0;
`ifdef WBACK_ARB_RR_EN
        m_ptr = 1'b0;
`endif
        alu_valid_i = 1'b1;
        #12;
        check("reset", {25'd0, wb_valid_o, alu_ready_o, mem_ready_o, obs_s}, 128'd0);
        alu_valid_i = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // ALU only
        alu_valid_i = 1'b1; alu_wena_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 32'h1234;
        wb_ready_i = 1'b1;
        tick("alu_only");
        tick("drain1");

        // Conflict
        alu_valid_i = 1'b1; alu_waddr_i = 5'd3; alu_wdata_i = 32'hA;
        mem_valid_i = 1'b1; mem_wena_i = 1'b1; mem_waddr_i = 5'd4; mem_wdata_i = 32'hB;
        tick("conf1");
        tick("conf2");
        tick("drain2");

        // Sustained conflict
        for (int i = 0; i < 4; i++) begin
            if (!alu_valid_i) begin
                alu_valid_i = 1'b1; alu_waddr_i = 5'(10 + i); alu_wdata_i = 32'h100 + 32'(i);
            end
            if (!mem_valid_i) begin
                mem_valid_i = 1'b1; mem_waddr_i = 5'(20 + i); mem_wdata_i = 32'h200 + 32'(i);
            end
            tick("both");
        end
        tick("tail1");
        tick("tail2");

        // Backpressure
        alu_valid_i = 1'b1; alu_waddr_i = 5'd7; alu_wdata_i = 32'h77;
        tick("bp_load");
        wb_ready_i = 1'b0;
        alu_valid_i = 1'b1; alu_waddr_i = 5'd8; alu_wdata_i = 32'h88;
        for (int i = 0; i < 3; i++) tick("bp_hold");
        wb_ready_i = 1'b1;
        tick("bp_release");
        tick("drain3");

        // x0 suppression and CSR fields
        alu_valid_i = 1'b1; alu_waddr_i = 5'd0; alu_wdata_i = 32'hDEAD;
        alu_csr_wena_i = 1'b1; alu_csr_waddr_i = 32'h305; alu_csr_wdata_i = 32'h8000_0000;
        tick("x0_csr");
        alu_csr_wena_i = 1'b0; alu_csr_waddr_i = 32'd0; alu_csr_wdata_i = 32'd0;
        mem_valid_i = 1'b1; mem_waddr_i = 5'd0; mem_wdata_i = 32'h5;
        tick("mem_x0");
        mem_valid_i = 1'b1; mem_waddr_i = 5'd9; mem_wdata_i = 32'h99;
        tick("mem_x9");
        tick("drain4");

        // Reset mid-operation
        alu_valid_i = 1'b1; alu_waddr_i = 5'd6; alu_wdata_i = 32'h66;
        tick("pre_rst");
        wb_ready_i = 1'b0;
        alu_valid_i = 1'b1; alu_waddr_i = 5'd2; alu_wdata_i = 32'h22;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_reset", {25'd0, wb_valid_o, alu_ready_o, mem_ready_o, obs_s}, 128'd0);
        sb_q.delete();
        m_valid = 1'b0;
`ifdef WBACK_ARB_RR_EN
        m_ptr = 1'b0;
`endif
        alu_valid_i = 1'b0;
        #2;
        reset = 1'b1;
        wb_ready_i = 1'b1;
        @(posedge clock);
        #1;
        check("post_reset", {127'd0, wb_valid_o}, 128'd0);
        alu_valid_i = 1'b1; alu_waddr_i = 5'd1; alu_wdata_i = 32'h11;
        mem_valid_i = 1'b1; mem_waddr_i = 5'd12; mem_wdata_i = 32'hCC;
        tick("resume1");
        tick("resume2");
        tick("drain5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
